ram_arb2: RTL

Two-requester arbiter sharing one port of the dual-port simulation/target RAM (registered address, one-cycle read latency, write committed on the clock's low phase). Requesters A and B issue single-word read/write accesses with a request/acknowledge handshake. The arbiter grants in round-robin order, with a bounded lock for short bursts, drives the RAM port, and routes returned read data to the owning requester one cycle later. The RAM clock-enable is tied high at integration.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb2_if.sv | 49 ++++
 rtl/ram_arb2_rr_pick2.sv | 37 +++
 rtl/ram_arb2.sv | 89 ++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam int CLockCntLen = 4;

  localparam int CAddrLenDef = 11;
  localparam int CDataLenDef = 8;
  localparam int CLockMaxDef = 4;

endpackage

// File: rtl/ram_arb2_if.sv
// Requester A/B handshake plus the shared RAM port.
interface ram_arb2_if #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8
);

  logic                AReqA;
  logic                ALockA;
  logic                AWrA;
  logic [CAddrLen-1:0] AAddrA;
  logic [CDataLen-1:0] AMosiA;
  logic                AAckA;
  logic                ARdVldA;
  logic [CDataLen-1:0] AMisoA;

  logic                AReqB;
  logic                ALockB;
  logic                AWrB;
  logic [CAddrLen-1:0] AAddrB;
  logic [CDataLen-1:0] AMosiB;
  logic                AAckB;
  logic                ARdVldB;
  logic [CDataLen-1:0] AMisoB;

  logic [CAddrLen-1:0] ARamAddr;
  logic [CDataLen-1:0] ARamMosi;
  logic                ARamWrEn;
  logic                ARamRdEn;
  logic [CDataLen-1:0] ARamMiso;

  modport master (
    output AReqA, ALockA, AWrA, AAddrA, AMosiA,
    output AReqB, ALockB, AWrB, AAddrB, AMosiB,
    output ARamMiso,
    input  AAckA, ARdVldA, AMisoA,
    input  AAckB, ARdVldB, AMisoB,
    input  ARamAddr, ARamMosi, ARamWrEn, ARamRdEn
  );

  modport slave (
    input  AReqA, ALockA, AWrA, AAddrA, AMosiA,
    input  AReqB, ALockB, AWrB, AAddrB, AMosiB,
    input  ARamMiso,
    output AAckA, ARdVldA, AMisoA,
    output AAckB, ARdVldB, AMisoB,
    output ARamAddr, ARamMosi, ARamWrEn, ARamRdEn
  );

endinterface

// File: rtl/ram_arb2_rr_pick2.sv
// Two-way round-robin pick; an active lock keeps the last winner.
module rr_pick2 (
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_b_i,
  input  logic lock_act_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic last_b_o
);

  logic both_a;

  // Under contention: locked owner keeps it, else the one not served last.
  assign both_a = lock_act_i ? !last_b_i : last_b_i;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    unique case (1'b1)
      (req_a_i && !req_b_i): gnt_a_o = 1'b1;
      (req_b_i && !req_a_i): gnt_b_o = 1'b1;
      (req_a_i && req_b_i): begin
        gnt_a_o = both_a;
        gnt_b_o = !both_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_b_o = last_b_i;
    if (gnt_a_o) last_b_o = 1'b0;
    if (gnt_b_o) last_b_o = 1'b1;
  end

endmodule

// File: rtl/ram_arb2.sv
// Round-robin arbiter with bounded lock sharing one RAM port.
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int CAddrLen = CAddrLenDef,
  parameter int CDataLen = CDataLenDef,
  parameter int CLockMax = CLockMaxDef
) (
  input logic         AClk,
  input logic         AResetN,
  ram_arb2_if.slave   bus
);

  localparam logic [CLockCntLen-1:0] LockMax =
    CLockCntLen'(CLockMax);
  localparam logic [CLockCntLen-1:0] CntOne =
    CLockCntLen'(1);

  logic                   last_q, last_d;
  logic [CLockCntLen-1:0] lock_cnt_q, lock_cnt_d;
  owner_e                 rd_own_q, rd_own_d;

  logic req_a, req_b;
  logic gnt_a, gnt_b, grant;
  logic lock_act;
  logic win_lock, other_req, win_wr;

  // No grants while reset is asserted.
  assign req_a = bus.AReqA & AResetN;
  assign req_b = bus.AReqB & AResetN;

  assign lock_act = (lock_cnt_q != '0) && (lock_cnt_q < LockMax);

  rr_pick2 u_pick (
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .last_b_i   (last_q),
    .lock_act_i (lock_act),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b),
    .last_b_o   (last_d)
  );

  assign grant     = gnt_a | gnt_b;
  assign win_lock  = gnt_a ? bus.ALockA : bus.ALockB;
  assign other_req = gnt_a ? bus.AReqB : bus.AReqA;
  assign win_wr    = gnt_a ? bus.AWrA : bus.AWrB;

  always_comb begin
    lock_cnt_d = '0;
    if (grant && win_lock && other_req) begin
      lock_cnt_d = (gnt_b == last_q) ? lock_cnt_q + CntOne : CntOne;
    end
  end

  always_comb begin
    rd_own_d = OWN_NONE;
    if (gnt_a && !bus.AWrA) rd_own_d = OWN_A;
    if (gnt_b && !bus.AWrB) rd_own_d = OWN_B;
  end

  always_ff @(posedge AClk or negedge AResetN) begin
    if (!AResetN) begin
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rd_own_q   <= OWN_NONE;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_own_q   <= rd_own_d;
    end
  end

  assign bus.AAckA = gnt_a;
  assign bus.AAckB = gnt_b;

  assign bus.ARamWrEn = grant & win_wr;
  assign bus.ARamRdEn = grant & !win_wr;
  assign bus.ARamAddr = gnt_a ? bus.AAddrA :
                        gnt_b ? bus.AAddrB : '0;
  assign bus.ARamMosi = gnt_a ? bus.AMosiA :
                        gnt_b ? bus.AMosiB : '0;

  assign bus.ARdVldA = (rd_own_q == OWN_A);
  assign bus.ARdVldB = (rd_own_q == OWN_B);
  assign bus.AMisoA  = bus.ARdVldA ? bus.ARamMiso : '0;
  assign bus.AMisoB  = bus.ARdVldB ? bus.ARamMiso : '0;

endmodule
